// File: rtl/chip_7458_pkg.sv
// Shared types and constants for the 7458 exhaustive tester and its golden model.
package chip_7458_pkg;

    localparam int NUM_VECTORS = 1024;
    localparam int VEC_W       = 10;
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);

    // Bit positions of the chip pins inside drive_vec
    localparam int P1A_IDX = 0;
    localparam int P1B_IDX = 1;
    localparam int P1C_IDX = 2;
    localparam int P1D_IDX = 3;
    localparam int P1E_IDX = 4;
    localparam int P1F_IDX = 5;
    localparam int P2A_IDX = 6;
    localparam int P2B_IDX = 7;
    localparam int P2C_IDX = 8;
    localparam int P2D_IDX = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_e;

endpackage

// File: rtl/chip_7458_golden.sv
// Combinational reference model of the 7458 dual AND-OR gate.
module chip_7458_golden
    import chip_7458_pkg::*;
(
    input  logic [VEC_W-1:0] vec_i,
    output logic             exp_p1y_o,
    output logic             exp_p2y_o
);

    assign exp_p1y_o = (vec_i[P1A_IDX] & vec_i[P1B_IDX] & vec_i[P1C_IDX])
                     | (vec_i[P1D_IDX] & vec_i[P1E_IDX] & vec_i[P1F_IDX]);

    assign exp_p2y_o = (vec_i[P2A_IDX] & vec_i[P2B_IDX])
                     | (vec_i[P2C_IDX] & vec_i[P2D_IDX]);

endmodule

// File: rtl/chip_7458_tester.sv
// Exhaustive sweep driver and checker for a 7458: drives all input vectors,
// compares the chip outputs with the golden model and reports the result.
//
// state  | meaning
// IDLE   | waiting for start, results of an aborted sweep still visible
// DRIVE  | vector register just updated, chip inputs changing
// SETTLE | down-counting SETTLE_CYCLES before the outputs are trusted
// CHECK  | sample chip outputs, score mismatch, advance or finish
// DONE   | sweep complete, results frozen until the next start
module chip_7458_tester
    import chip_7458_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_CNT_W     = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [VEC_W-1:0]     drive_vec,
    input  logic                 dut_p1y,
    input  logic                 dut_p2y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 first_fail_valid,
    output logic [VEC_W-1:0]     first_fail_vec
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
        SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    state_e                state_q, state_d;
    logic [VEC_W-1:0]      vec_q, vec_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [ERR_CNT_W-1:0]  err_q, err_d;
    logic                  ffv_q, ffv_d;
    logic [VEC_W-1:0]      ffvec_q, ffvec_d;

    logic exp_p1y;
    logic exp_p2y;
    logic mismatch;

    chip_7458_golden u_golden (
        .vec_i     (vec_q),
        .exp_p1y_o (exp_p1y),
        .exp_p2y_o (exp_p2y)
    );

    assign mismatch = (dut_p1y != exp_p1y) | (dut_p2y != exp_p2y);

    assign busy             = (state_q == ST_DRIVE) | (state_q == ST_SETTLE) | (state_q == ST_CHECK);
    assign done             = (state_q == ST_DONE);
    assign pass             = done & (err_q == '0);
    assign drive_vec        = vec_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffvec_d  = ffvec_q;

        // Abort only applies mid-sweep and overrides a simultaneous start.
        if (busy && abort) begin
            state_d = ST_IDLE;
            vec_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_DRIVE;
                        vec_d   = '0;
                        err_d   = '0;
                        ffv_d   = 1'b0;
                        ffvec_d = '0;
                    end
                end
                ST_DRIVE: begin
                    if (SETTLE_CYCLES > 0) begin
                        state_d  = ST_SETTLE;
                        settle_d = SETTLE_LOAD;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        state_d = ST_CHECK;
                    end else begin
                        settle_d = settle_q - SETTLE_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + ERR_CNT_W'(1);
                        end
                        if (!ffv_q) begin
                            ffv_d   = 1'b1;
                            ffvec_d = vec_q;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + VEC_W'(1);
                        state_d = ST_DRIVE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            ffv_q    <= ffv_d;
            ffvec_q  <= ffvec_d;
        end
    end

endmodule

// File: tb/tb_chip_7458_tester.sv
// Bench for chip_7458_tester: three tester instances (settle 1 / settle 0 / 8-bit
// error counter) each looped through a behavioural chip with selectable faults.
module tb_chip_7458_tester;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic        ffv;
        logic [10:0] ec;
        logic [9:0]  ffvec;
        logic [9:0]  dv;
    } stat_t;

    typedef struct {
        int k;
        int mode;
        int cycles;
        int err;
        int ffv;
        int ffvec;
        int pass;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start_s;
    logic [2:0] abort_s;
    int         mode_s [3];

    logic [9:0]  dv0, dv1, dv2, ffvec0, ffvec1, ffvec2;
    logic [10:0] ec0, ec1;
    logic [7:0]  ec2;
    logic busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
    logic ffv0, ffv1, ffv2;
    logic p1y0, p1y1, p1y2, p2y0, p2y1, p2y2;

    bit flip1 [1024];
    bit flip2 [1024];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Golden behaviour written as "all pins of a gate group high".
    function automatic logic [1:0] golden(input logic [9:0] v);
        logic g1, g2;
        g1 = (v[2:0] == 3'b111) || (v[5:3] == 3'b111);
        g2 = (v[7:6] == 2'b11) || (v[9:8] == 2'b11);
        return {g2, g1};
    endfunction

    // Chip under test: 0 good, 1 p1y stuck 0, 2 p2y inverted, 3 random flips.
    function automatic logic [1:0] chip_out(input int mode, input logic [9:0] v);
        logic [1:0] g;
        g = golden(v);
        case (mode)
            1:       return {g[1], 1'b0};
            2:       return {~g[1], g[0]};
            3:       return {g[1] ^ flip2[v], g[0] ^ flip1[v]};
            default: return g;
        endcase
    endfunction

    assign {p2y0, p1y0} = chip_out(mode_s[0], dv0);
    assign {p2y1, p1y1} = chip_out(mode_s[1], dv1);
    assign {p2y2, p1y2} = chip_out(mode_s[2], dv2);

    chip_7458_tester #(.SETTLE_CYCLES(1), .ERR_CNT_W(11)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
        .drive_vec(dv0), .dut_p1y(p1y0), .dut_p2y(p2y0), .busy(busy0),
        .done(done0), .pass(pass0), .err_count(ec0),
        .first_fail_valid(ffv0), .first_fail_vec(ffvec0));

    chip_7458_tester #(.SETTLE_CYCLES(0), .ERR_CNT_W(11)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
        .drive_vec(dv1), .dut_p1y(p1y1), .dut_p2y(p2y1), .busy(busy1),
        .done(done1), .pass(pass1), .err_count(ec1),
        .first_fail_valid(ffv1), .first_fail_vec(ffvec1));

    chip_7458_tester #(.SETTLE_CYCLES(1), .ERR_CNT_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .abort(abort_s[2]),
        .drive_vec(dv2), .dut_p1y(p1y2), .dut_p2y(p2y2), .busy(busy2),
        .done(done2), .pass(pass2), .err_count(ec2),
        .first_fail_valid(ffv2), .first_fail_vec(ffvec2));

    function automatic stat_t get_st(input int k);
        case (k)
            0:       return {busy0, done0, pass0, ffv0, ec0, ffvec0, dv0};
            1:       return {busy1, done1, pass1, ffv1, ec1, ffvec1, dv1};
            default: return {busy2, done2, pass2, ffv2, 11'(ec2), ffvec2, dv2};
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference sweep: count mismatching vectors (saturating) and the first one.
    function automatic void ref_sweep(input int mode, input int w, output int cnt, output int first);
        logic [9:0] v;
        cnt   = 0;
        first = -1;
        for (int i = 0; i < 1024; i++) begin
            v = 10'(i);
            if (chip_out(mode, v) != golden(v)) begin
                if (cnt < (1 << w) - 1) cnt++;
                if (first < 0) first = i;
            end
        end
    endfunction

    // One start pulse, then follow busy; drive_vec must equal cycle/period throughout.
    task automatic run_sweep(input int k, input int mode, input int poke,
                             output int cycles, output bit seq_ok);
        int    per;
        stat_t st;
        per = (k == 1) ? 2 : 3;
        mode_s[k] = mode;
        @(negedge clk); start_s[k] = 1'b1;
        @(negedge clk); start_s[k] = 1'b0;
        cycles = 0;
        seq_ok = 1'b1;
        st = get_st(k);
        while (st.busy && cycles < 4000) begin
            if (st.dv != 10'(cycles / per)) seq_ok = 1'b0;
            if (st.done) seq_ok = 1'b0;
            cycles++;
            start_s[k] = (cycles == poke);
            @(negedge clk);
            st = get_st(k);
        end
        start_s[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl [7];
        stat_t st;
        int    cyc, cnt, first, n;
        bit    ok;

        rst_n   = 1'b0;
        start_s = '0;
        abort_s = '0;
        mode_s  = '{0, 0, 0};
        for (int i = 0; i < 1024; i++) begin
            flip1[i] = ($urandom_range(0, 47) == 0);
            flip2[i] = ($urandom_range(0, 47) == 0);
        end

        tbl[0] = '{0, 0, 3072, 0,    0, 0, 1};
        tbl[1] = '{0, 1, 3072, 240,  1, 7, 0};
        tbl[2] = '{0, 2, 3072, 1024, 1, 0, 0};
        tbl[3] = '{2, 2, 3072, 255,  1, 0, 0};
        tbl[4] = '{1, 0, 2048, 0,    0, 0, 1};
        ref_sweep(3, 11, cnt, first);
        tbl[5] = '{0, 3, 3072, cnt, (cnt > 0) ? 1 : 0, (first < 0) ? 0 : first, (cnt == 0) ? 1 : 0};
        ref_sweep(3, 11, cnt, first);
        tbl[6] = '{1, 3, 2048, cnt, (cnt > 0) ? 1 : 0, (first < 0) ? 0 : first, (cnt == 0) ? 1 : 0};

        #1;
        for (int k = 0; k < 3; k++) begin
            st = get_st(k);
            chk($sformatf("reset%0d flags", k), {st.busy, st.done, st.pass, st.ffv}, 0);
            chk($sformatf("reset%0d err", k), st.ec, 0);
            chk($sformatf("reset%0d vecs", k), {st.ffvec, st.dv}, 0);
        end
        #20;
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_sweep(tbl[i].k, tbl[i].mode, -1, cyc, ok);
            st = get_st(tbl[i].k);
            chk($sformatf("t%0d busy_cycles", i), cyc, tbl[i].cycles);
            chk($sformatf("t%0d vec_seq", i), ok, 1);
            chk($sformatf("t%0d done", i), st.done, 1);
            chk($sformatf("t%0d pass", i), st.pass, tbl[i].pass);
            chk($sformatf("t%0d err", i), st.ec, tbl[i].err);
            chk($sformatf("t%0d ffv", i), st.ffv, tbl[i].ffv);
            chk($sformatf("t%0d ffvec", i), st.ffvec, tbl[i].ffvec);
        end

        // Start pulsed mid-sweep must not disturb the vector sequence.
        run_sweep(0, 1, 500, cyc, ok);
        st = get_st(0);
        chk("midstart busy_cycles", cyc, 3072);
        chk("midstart vec_seq", ok, 1);
        chk("midstart err", st.ec, 240);

        // Abort (with simultaneous start) at vector 100.
        mode_s[0] = 2;
        @(negedge clk); start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        n = 0;
        while (dv0 != 10'd100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("abort reach_vec100", dv0, 100);
        start_s[0] = 1'b1; abort_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0; abort_s[0] = 1'b0;
        st = get_st(0);
        chk("abort busy", st.busy, 0);
        chk("abort done", st.done, 0);
        chk("abort drive_vec", st.dv, 0);
        chk("abort partial_err", st.ec, 100);
        chk("abort partial_ffv", st.ffv, 1);
        repeat (3) @(negedge clk);
        chk("abort stays_idle", busy0, 0);
        mode_s[0] = 0;
        start_s[0] = 1'b1; abort_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0; abort_s[0] = 1'b0;
        st = get_st(0);
        chk("restart busy", st.busy, 1);
        chk("restart cleared", {st.ffv, st.ec, st.dv}, 0);
        n = 0;
        while (busy0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("restart pass", {done0, pass0}, 3);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        chk("abort_in_done ignored", {done0, pass0}, 3);

        // Asynchronous reset between clock edges in the middle of a failing sweep.
        mode_s[0] = 2;
        @(negedge clk); start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        repeat (200) @(negedge clk);
        chk("prereset err_nonzero", (ec0 != 0) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1;
        st = get_st(0);
        chk("asyncrst flags", {st.busy, st.done, st.pass, st.ffv}, 0);
        chk("asyncrst err", st.ec, 0);
        chk("asyncrst vecs", {st.ffvec, st.dv}, 0);
        @(negedge clk); rst_n = 1'b1;
        run_sweep(0, 0, -1, cyc, ok);
        st = get_st(0);
        chk("postrst busy_cycles", cyc, 3072);
        chk("postrst vec_seq", ok, 1);
        chk("postrst pass", {st.done, st.pass}, 3);
        chk("postrst err", st.ec, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
